// File: rtl/gcd_pkg.sv
// gcd_pkg: shared constants for the subtractive GCD engine.
// Holds widths, mux select codes and controller state encodings.
package gcd_pkg;

    localparam int GCD_WIDTH = 4;
    localparam int GCD_CNT_W = 8;

    // Operand register source select
    localparam logic SEL_INPUT = 1'b0;
    localparam logic SEL_SUB   = 1'b1;

    // Controller states, shared so controller and bench agree
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SUB_X = 3'd3,
        ST_SUB_Y = 3'd4,
        ST_DONE  = 3'd5,
        ST_ABORT = 3'd6
    } gcd_state_e;

endpackage

// File: rtl/gcd_operand_reg.sv
// gcd_operand_reg: WIDTH-bit operand register, 2:1 input/difference mux.
// Ports: CLK, RST_N (sync, active-low), ld, sel, din, other, q (q <= q - other).
module gcd_operand_reg
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ld,
    input  logic             sel,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] other,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] q_nxt;

    // Modulo 2^WIDTH; underflow wraps silently
    assign diff  = q - other;
    assign q_nxt = (sel == SEL_SUB) ? diff : din;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q <= '0;
        end else if (ld) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/gcd_datapath.sv
// gcd_datapath: X/Y operand registers, comparators, result reg, iter counter.
// In: CLK, RST_N, x_i, y_i, x_ld/x_sel, y_ld/y_sel, d_ld.
// Out: x_neq_y, x_lt_y, op_zero, d_o, d_valid, iter_cnt.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int CNT_W = GCD_CNT_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             x_ld,
    input  logic             x_sel,
    input  logic             y_ld,
    input  logic             y_sel,
    input  logic             d_ld,
    output logic             x_neq_y,
    output logic             x_lt_y,
    output logic             op_zero,
    output logic [WIDTH-1:0] d_o,
    output logic             d_valid,
    output logic [CNT_W-1:0] iter_cnt
);

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             ld_ev;
    logic             sub_ev;

    // Both instances see pre-edge X/Y, so simultaneous loads are well defined
    gcd_operand_reg #(.WIDTH(WIDTH)) u_x (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ld    (x_ld),
        .sel   (x_sel),
        .din   (x_i),
        .other (y_q),
        .q     (x_q)
    );

    gcd_operand_reg #(.WIDTH(WIDTH)) u_y (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ld    (y_ld),
        .sel   (y_sel),
        .din   (y_i),
        .other (x_q),
        .q     (y_q)
    );

    assign x_neq_y = (x_q != y_q);
    assign x_lt_y  = (x_q < y_q);
    assign op_zero = (x_q == '0) || (y_q == '0);

    assign ld_ev  = (x_ld && (x_sel == SEL_INPUT))
                 || (y_ld && (y_sel == SEL_INPUT));
    assign sub_ev = (x_ld && (x_sel == SEL_SUB))
                 || (y_ld && (y_sel == SEL_SUB));

    // Operand load restarts the count; subtracts saturate at all-ones
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            iter_cnt <= '0;
        end else if (ld_ev) begin
            iter_cnt <= '0;
        end else if (sub_ev && (iter_cnt != '1)) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

    // New operands invalidate the result even if d_ld fires together
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            d_o     <= '0;
            d_valid <= 1'b0;
        end else begin
            if (d_ld) begin
                d_o <= x_q;
            end
            if (ld_ev) begin
                d_valid <= 1'b0;
            end else if (d_ld) begin
                d_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_datapath.sv
// tb_gcd_datapath: scoreboard bench for gcd_datapath.
// Two DUTs share stimulus: default CNT_W and CNT_W=2 for saturation.
module tb_gcd_datapath;
    import gcd_pkg::*;

    logic       CLK;
    logic       RST_N;
    logic [3:0] x_i, y_i;
    logic       x_ld, x_sel, y_ld, y_sel, d_ld;

    logic       neq_a, lt_a, oz_a, dv_a;
    logic [3:0] d_a;
    logic [7:0] cnt_a;
    logic       neq_b, lt_b, oz_b, dv_b;
    logic [3:0] d_b;
    logic [1:0] cnt_b;

    typedef struct packed {
        logic       neq;
        logic       lt;
        logic       oz;
        logic [3:0] d;
        logic       dv;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mx, my, md;
    logic       mv;
    logic [7:0] mc8;
    logic [1:0] mc2;
    int         n_checks = 0;
    int         n_err = 0;

    gcd_datapath #(.WIDTH(4), .CNT_W(8)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .x_i(x_i), .y_i(y_i),
        .x_ld(x_ld), .x_sel(x_sel), .y_ld(y_ld), .y_sel(y_sel),
        .d_ld(d_ld), .x_neq_y(neq_a), .x_lt_y(lt_a),
        .op_zero(oz_a), .d_o(d_a), .d_valid(dv_a),
        .iter_cnt(cnt_a)
    );

    gcd_datapath #(.WIDTH(4), .CNT_W(2)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .x_i(x_i), .y_i(y_i),
        .x_ld(x_ld), .x_sel(x_sel), .y_ld(y_ld), .y_sel(y_sel),
        .d_ld(d_ld), .x_neq_y(neq_b), .x_lt_y(lt_b),
        .op_zero(oz_b), .d_o(d_b), .d_valid(dv_b),
        .iter_cnt(cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, obs, exp_v, $time);
        end
    endtask

    // Advance the reference model by one edge and push expectations
    task automatic model_step();
        logic       lev, sev;
        logic [3:0] nx, ny;
        exp_t       e;
        if (!RST_N) begin
            mx = 0; my = 0; md = 0; mv = 0; mc8 = 0; mc2 = 0;
        end else begin
            lev = (x_ld && !x_sel) || (y_ld && !y_sel);
            sev = (x_ld && x_sel) || (y_ld && y_sel);
            nx = x_ld ? (x_sel ? 4'(mx - my) : x_i) : mx;
            ny = y_ld ? (y_sel ? 4'(my - mx) : y_i) : my;
            if (d_ld) md = mx;
            if (lev) mv = 1'b0;
            else if (d_ld) mv = 1'b1;
            if (lev) begin
                mc8 = 0; mc2 = 0;
            end else if (sev) begin
                if (mc8 != 8'hff) mc8 = mc8 + 1;
                if (mc2 != 2'h3) mc2 = mc2 + 1;
            end
            mx = nx; my = ny;
        end
        e.neq = (mx != my);
        e.lt  = (mx < my);
        e.oz  = (mx == 0) || (my == 0);
        e.d   = md;
        e.dv  = mv;
        e.c8  = mc8;
        e.c2  = mc2;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("x_neq_y", 32'(neq_a), 32'(e.neq));
        chk("x_lt_y",  32'(lt_a),  32'(e.lt));
        chk("op_zero", 32'(oz_a),  32'(e.oz));
        chk("d_o",     32'(d_a),   32'(e.d));
        chk("d_valid", 32'(dv_a),  32'(e.dv));
        chk("iter_cnt", 32'(cnt_a), 32'(e.c8));
        chk("x_neq_y_w2", 32'(neq_b), 32'(e.neq));
        chk("x_lt_y_w2",  32'(lt_b),  32'(e.lt));
        chk("op_zero_w2", 32'(oz_b),  32'(e.oz));
        chk("d_o_w2",     32'(d_b),   32'(e.d));
        chk("d_valid_w2", 32'(dv_b),  32'(e.dv));
        chk("iter_cnt_w2", 32'(cnt_b), 32'(e.c2));
    endtask

    task automatic cyc(input logic rst, input logic [3:0] xi,
                       input logic [3:0] yi, input logic xl,
                       input logic xs, input logic yl,
                       input logic ys, input logic dl);
        @(negedge CLK);
        RST_N = rst; x_i = xi; y_i = yi;
        x_ld = xl; x_sel = xs; y_ld = yl; y_sel = ys; d_ld = dl;
        model_step();
        @(posedge CLK);
        #1;
        compare_out();
    endtask

    initial begin
        RST_N = 0; x_i = 0; y_i = 0;
        x_ld = 0; x_sel = 0; y_ld = 0; y_sel = 0; d_ld = 0;
        mx = 0; my = 0; md = 0; mv = 0; mc8 = 0; mc2 = 0;

        // Reset with strobes asserted
        cyc(0, 4'd5, 4'd7, 1, 1, 1, 0, 1);
        cyc(0, 4'd3, 4'd9, 1, 0, 1, 1, 1);
        chk("rst_op_zero", 32'(oz_a), 32'd1);
        chk("rst_d_valid", 32'(dv_a), 32'd0);

        // GCD(12,8)
        cyc(1, 4'd12, 4'd8, 1, SEL_INPUT, 1, SEL_INPUT, 0);
        chk("ld_neq", 32'(neq_a), 32'd1);
        cyc(1, 4'd0, 4'd0, 1, SEL_SUB, 0, 0, 0);
        cyc(1, 4'd0, 4'd0, 0, 0, 1, SEL_SUB, 0);
        cyc(1, 4'd0, 4'd0, 0, 0, 0, 0, 1);
        chk("gcd12_8", 32'(d_a), 32'd4);
        chk("gcd12_8_cnt", 32'(cnt_a), 32'd2);

        // New operands drop d_valid, keep d_o
        cyc(1, 4'd9, 4'd3, 1, 0, 1, 0, 0);
        chk("reload_dv", 32'(dv_a), 32'd0);
        chk("reload_d", 32'(d_a), 32'd4);

        // Simultaneous subtract: 6,4 -> 2,14, one count
        cyc(1, 4'd6, 4'd4, 1, 0, 1, 0, 0);
        cyc(1, 4'd0, 4'd0, 1, 1, 1, 1, 0);
        chk("simul_cnt", 32'(cnt_a), 32'd1);
        cyc(1, 4'd0, 4'd0, 0, 0, 0, 0, 1);
        chk("simul_x", 32'(d_a), 32'd2);

        // d_ld with operand load: old X captured, valid low
        cyc(1, 4'd10, 4'd0, 1, 0, 0, 0, 1);
        chk("dld_ld_d", 32'(d_a), 32'd2);
        chk("dld_ld_dv", 32'(dv_a), 32'd0);

        // Saturation: 5 subtracts
        cyc(1, 4'd15, 4'd1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 1, 0, 0, 0);
        chk("sat_w2", 32'(cnt_b), 32'd3);
        chk("sat_w8", 32'(cnt_a), 32'd5);

        // Load and subtract together: load wins
        cyc(1, 4'd0, 4'd7, 1, 1, 1, 0, 0);
        chk("ld_wins", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 1, 1, 0);

        // Reset mid-sequence
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 4'd3, 4'd3, 1, 1, 1, 1, 1);
        chk("midrst_cnt", 32'(cnt_a), 32'd0);
        chk("midrst_d", 32'(d_a), 32'd0);

        // Zero operand visible to controller
        cyc(1, 4'd0, 4'd5, 1, 0, 1, 0, 0);
        chk("zero_oz", 32'(oz_a), 32'd1);
        chk("zero_lt", 32'(lt_a), 32'd1);

        // Random strobes
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 15) != 0),
                4'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom),
                1'($urandom));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_datapath.md
Name: gcd_datapath

Overview:
- Datapath half of the subtractive GCD engine; sits directly beside the GCD controller FSM and is driven by it.
- Holds operand registers X and Y, the input/subtract muxes, a subtractor per register, and the comparators that feed the controller.
- Adds a registered result port with a valid flag, plus a saturating iteration counter for debug and verification.
- Controller load/select strobes are sampled on the rising edge of CLK.

Parameters:
- WIDTH, 4, operand/result width in bits.
- CNT_W, 8, iteration counter width in bits.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- x_i  input  WIDTH  X operand from input switches.
- y_i  input  WIDTH  Y operand from input switches.
- x_ld  input  1  load enable for X register.
- x_sel  input  1  X source: 0 = x_i, 1 = X − Y.
- y_ld  input  1  load enable for Y register.
- y_sel  input  1  Y source: 0 = y_i, 1 = Y − X.
- d_ld  input  1  capture X into the result register.
- x_neq_y  output  1  X != Y (combinational from the registers).
- x_lt_y  output  1  X < Y, unsigned (combinational from the registers).
- op_zero  output  1  X == 0 or Y == 0 (combinational from the registers).
- d_o  output  WIDTH  registered GCD result.
- d_valid  output  1  d_o holds a result for the current operands.
- iter_cnt  output  CNT_W  number of subtract loads since the last operand load.

Behaviour:
- Reset: RST_N low at a rising edge clears X, Y, d_o, d_valid and iter_cnt to 0. Reset overrides all strobes in the same cycle. Reset mid-computation abandons the computation; no partial result is retained.
- After reset, the comparator outputs are x_neq_y = 0, x_lt_y = 0, op_zero = 1.
- X update: if x_ld, then X <= (x_sel ? X − Y : x_i).
- Y update: if y_ld, then Y <= (y_sel ? Y − X : y_i).
- Subtraction is WIDTH-bit unsigned modulo 2^WIDTH. An underflow wraps and is not flagged; the controller only subtracts the smaller from the larger.
- Both loads in one cycle: both right-hand sides use the pre-edge values of X and Y. Example: X=6, Y=4 with both subtract strobes gives X=2, Y=14 (WIDTH=4). This is defined but not a legal controller use.
- Comparators are purely combinational on the registered X/Y, with zero latency to the controller. A controller decision sees the values from the previous load.
- Operand load event: any cycle where (x_ld & ~x_sel) or (y_ld & ~y_sel). On that event:
  - iter_cnt <= 0;
  - d_valid <= 0.
- Subtract event: any cycle where (x_ld & x_sel) or (y_ld & y_sel), with no operand load event in the same cycle. iter_cnt increments by 1 and saturates at all-ones. Simultaneous X and Y subtracts count as 1.
- If a load event and a subtract event coincide, the load event wins for iter_cnt.
- d_ld: d_o <= X (pre-edge value) and d_valid <= 1. d_o holds until the next d_ld or reset. d_valid clears on the next operand load event.
- If d_ld and an operand load event coincide, d_o captures the old X and d_valid ends at 0.
- Zero operands: if X or Y is 0, subtraction never terminates. op_zero is exported so the controller can abort; the datapath takes no action itself.
- Latency: operand to register, 1 clock. Register to comparator outputs, 0 clocks. d_ld to d_o/d_valid, 1 clock.

Decomposition:
- Shared package gcd_pkg holds:
  - WIDTH and CNT_W defaults;
  - sel encodings SEL_INPUT = 1'b0 and SEL_SUB = 1'b1;
  - the controller state encodings, so the controller and testbench agree.
- One natural sub-module: gcd_operand_reg, a WIDTH-bit register with a 2:1 input/difference mux and load enable. It is instantiated twice, for X and for Y; the Y instance has its subtractor operands swapped.
- The comparators, counter and result register stay in the top level.

Test Plan:
- Reset: drive arbitrary strobes with RST_N=0 for 2 cycles -> X=Y=d_o=0, d_valid=0, iter_cnt=0, op_zero=1.
- Load x_i=12, y_i=8 (x_ld=y_ld=1, sel=0) -> X=12, Y=8; x_neq_y=1, x_lt_y=0, op_zero=0, iter_cnt=0.
- Bench-driven GCD(12,8) sequence: X<=X−Y (4), Y<=Y−X (4), then d_ld -> d_o=4, d_valid=1, iter_cnt=2.
- Simultaneous subtract with X=6, Y=4, both sel=1 -> X=2, Y=14, iter_cnt +1 only.
- With d_valid=1, load x_i=9, y_i=3 -> d_valid=0, iter_cnt=0, d_o still 4.
- Counter saturation with CNT_W=2: 5 subtract loads -> iter_cnt=3. Then RST_N=0 mid-sequence for one cycle -> all outputs at reset values on the next cycle.
